// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with hold/bubble control, E-stage decode,
// and a mult/div issue pulse plus busy counter for HI/LO hazard stalls.
module id_ex_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_AUX  = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold_e,
  input  logic                      clr_e,
  input  logic [31:0]               instr_d,
  input  logic [DATA_W-1:0]         pc_d,
  input  logic                      cmprst_d,
  input  logic [NUM_AUX*DATA_W-1:0] aux_d,
  output logic [31:0]               instr_e,
  output logic [DATA_W-1:0]         pc_e,
  output logic                      cmprst_e,
  output logic [NUM_AUX*DATA_W-1:0] aux_e,
  output logic                      valid_e,
  output logic                      alu_srcb,
  output logic [3:0]                alu_ctrl,
  output logic [1:0]                reg_dst,
  output logic                      md_start,
  output logic [1:0]                md_op,
  output logic                      md_busy
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  logic [31:0]       instr_reg;
  logic [DATA_W-1:0] pc_reg;
  logic              cmprst_reg;
  logic              valid_reg;
  logic [3:0]        cnt_reg, cnt_next;
  logic              md_fired_reg, md_fired_next;
  logic              load_e;

  assign load_e = ~clr_e & ~hold_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_reg  <= '0;
      pc_reg     <= '0;
      cmprst_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else if (clr_e) begin
      instr_reg  <= '0;
      pc_reg     <= '0;
      cmprst_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else if (!hold_e) begin
      instr_reg  <= instr_d;
      pc_reg     <= pc_d;
      cmprst_reg <= cmprst_d;
      valid_reg  <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AUX; gi++) begin : g_aux
      logic [DATA_W-1:0] aux_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)       aux_reg <= '0;
        else if (clr_e)   aux_reg <= '0;
        else if (!hold_e) aux_reg <= aux_d[gi*DATA_W +: DATA_W];
      end
      assign aux_e[gi*DATA_W +: DATA_W] = aux_reg;
    end
  endgenerate

  assign instr_e  = instr_reg;
  assign pc_e     = pc_reg;
  assign cmprst_e = cmprst_reg;
  assign valid_e  = valid_reg;

  logic [5:0] op, funct;
  logic       is_r, is_md;
  assign op    = instr_reg[31:26];
  assign funct = instr_reg[5:0];
  assign is_r  = (op == 6'h00);
  assign is_md = is_r && (funct[5:2] == 4'b0110);

  always_comb begin
    alu_srcb = 1'b0;
    alu_ctrl = 4'd0;
    reg_dst  = 2'd0;
    if (valid_reg) begin
      alu_srcb = (op == 6'h0D) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h0F);
      if (is_r && funct == 6'h23)      alu_ctrl = 4'd1;
      else if (op == 6'h0D)            alu_ctrl = 4'd2;
      else if (is_r && funct == 6'h0A) alu_ctrl = 4'd3;
      if (is_r && (funct == 6'h21 || funct == 6'h23 || funct == 6'h0A ||
                   funct == 6'h10 || funct == 6'h12))
        reg_dst = 2'd1;
      else if (op == 6'h03)
        reg_dst = 2'd2;
    end
  end

  // A held md instruction issues once; md_fired re-arms only when E changes.
  assign md_start = valid_reg & is_md & (cnt_reg == 4'd0) & ~md_fired_reg;
  assign md_op    = (valid_reg & is_md) ? funct[1:0] : 2'd0;
  assign md_busy  = md_start | (cnt_reg != 4'd0);

  always_comb begin
    cnt_next      = cnt_reg;
    md_fired_next = md_fired_reg;
    if (md_start)
      cnt_next = funct[1] ? DIV_CNT : MULT_CNT;
    else if (cnt_reg != 4'd0)
      cnt_next = cnt_reg - 4'd1;
    if (clr_e || load_e)
      md_fired_next = 1'b0;
    else if (md_start)
      md_fired_next = 1'b1;
  end

  // The counter ignores clr_e so a flushed mult/div still runs to completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg      <= 4'd0;
      md_fired_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      md_fired_reg <= md_fired_next;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes hand-computed expectations,
// a monitor pops one per clock and compares against the DUT outputs.
module tb_id_ex_stage;
  localparam int DW = 16;
  localparam int NA = 3;

  localparam logic [31:0] ADDU = 32'h00221821;
  localparam logic [31:0] SUBU = 32'h00221823;
  localparam logic [31:0] ORI  = 32'h34220005;
  localparam logic [31:0] JAL  = 32'h0C000100;
  localparam logic [31:0] MOVZ = 32'h0022180A;
  localparam logic [31:0] LW   = 32'h8C220004;
  localparam logic [31:0] MULT = 32'h00220018;
  localparam logic [31:0] DIV  = 32'h0022001A;
  localparam logic [31:0] NOP  = 32'h00000000;
  localparam logic [47:0] AUX3 = 48'h0003_0002_0001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hold_e = 1'b0, clr_e = 1'b0;
  logic [31:0] instr_d = '0;
  logic [DW-1:0] pc_d = '0;
  logic cmprst_d = 1'b0;
  logic [NA*DW-1:0] aux_d = '0;
  logic [31:0] instr_e;
  logic [DW-1:0] pc_e;
  logic cmprst_e;
  logic [NA*DW-1:0] aux_e;
  logic valid_e, alu_srcb, md_start, md_busy;
  logic [3:0] alu_ctrl;
  logic [1:0] reg_dst, md_op;

  id_ex_stage #(.DATA_W(DW), .NUM_AUX(NA), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .hold_e(hold_e), .clr_e(clr_e),
    .instr_d(instr_d), .pc_d(pc_d), .cmprst_d(cmprst_d), .aux_d(aux_d),
    .instr_e(instr_e), .pc_e(pc_e), .cmprst_e(cmprst_e), .aux_e(aux_e),
    .valid_e(valid_e), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .reg_dst(reg_dst), .md_start(md_start), .md_op(md_op), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] instr;
    logic [DW-1:0] pc;
    logic        cmp;
    logic [47:0] aux;
    logic        valid, srcb, start, busy;
    logic [3:0]  ctrl;
    logic [1:0]  dst, op;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0, n_step = 0;

  logic [31:0] m_instr = '0;
  logic [DW-1:0] m_pc = '0;
  logic m_cmp = 1'b0, m_valid = 1'b0;
  logic [47:0] m_aux = '0;

  function automatic void chk(int id, string f, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL step%0d %s: got %0h want %0h", id, f, got, want);
    end
  endfunction

  task automatic step(input logic r, h, c, input logic [31:0] ins, input logic [DW-1:0] pc,
                      input logic cm, input logic [47:0] ax, input logic sb,
                      input logic [3:0] ctl, input logic [1:0] dst, input logic st,
                      input logic [1:0] op, input logic bz);
    exp_t e;
    @(negedge clk);
    reset = r; hold_e = h; clr_e = c;
    instr_d = ins; pc_d = pc; cmprst_d = cm; aux_d = ax;
    if (!r || c) begin
      m_instr = '0; m_pc = '0; m_cmp = 1'b0; m_aux = '0; m_valid = 1'b0;
    end else if (!h) begin
      m_instr = ins; m_pc = pc; m_cmp = cm; m_aux = ax; m_valid = 1'b1;
    end
    e.id = n_step; e.instr = m_instr; e.pc = m_pc; e.cmp = m_cmp; e.aux = m_aux;
    e.valid = m_valid; e.srcb = sb; e.ctrl = ctl; e.dst = dst;
    e.start = st; e.op = op; e.busy = bz;
    q.push_back(e);
    $display("step%0d r=%0b h=%0b c=%0b instr=%h pc=%h", n_step, r, h, c, ins, pc);
    n_step++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.id, "instr_e", 64'(instr_e), 64'(e.instr));
        chk(e.id, "pc_e", 64'(pc_e), 64'(e.pc));
        chk(e.id, "cmprst_e", 64'(cmprst_e), 64'(e.cmp));
        chk(e.id, "aux_e", 64'(aux_e), 64'(e.aux));
        chk(e.id, "valid_e", 64'(valid_e), 64'(e.valid));
        chk(e.id, "alu_srcb", 64'(alu_srcb), 64'(e.srcb));
        chk(e.id, "alu_ctrl", 64'(alu_ctrl), 64'(e.ctrl));
        chk(e.id, "reg_dst", 64'(reg_dst), 64'(e.dst));
        chk(e.id, "md_start", 64'(md_start), 64'(e.start));
        chk(e.id, "md_busy", 64'(md_busy), 64'(e.busy));
        if (e.start) chk(e.id, "md_op", 64'(md_op), 64'(e.op));
      end
    end
  end

  initial begin : stim
    // reset held low: everything zero regardless of D inputs
    step(0,0,0, ADDU, 16'h1111, 1, 48'hAAAA_BBBB_CCCC, 0,0,0, 0,0,0);
    step(0,0,0, ADDU, 16'h1112, 1, 48'hAAAA_BBBB_CCCC, 0,0,0, 0,0,0);
    // decode sweep
    step(1,0,0, ADDU, 16'h1000, 1, AUX3, 0,0,1, 0,0,0);
    step(1,0,0, ORI,  16'h1004, 0, 48'h1234_5678_9ABC, 1,2,0, 0,0,0);
    step(1,0,0, SUBU, 16'h1008, 1, 48'h0000_FFFF_0000, 0,1,1, 0,0,0);
    step(1,0,0, JAL,  16'h100C, 0, 48'h1, 0,0,2, 0,0,0);
    step(1,0,0, MOVZ, 16'h1010, 1, 48'h2, 0,3,1, 0,0,0);
    step(1,0,0, LW,   16'h1014, 0, 48'h3, 1,0,0, 0,0,0);
    step(1,0,0, NOP,  16'h1018, 1, 48'h4, 0,0,0, 0,0,0);
    // hold keeps E while D changes, then hold+clr gives a bubble
    step(1,0,0, ADDU, 16'h3004, 1, 48'h5, 0,0,1, 0,0,0);
    for (int i = 0; i < 3; i++)
      step(1,1,0, ORI, 16'h4000 + 16'(i), 0, 48'h6, 0,0,1, 0,0,0);
    step(1,1,1, ORI, 16'h4010, 1, 48'h7, 0,0,0, 0,0,0);
    // mult issue, held three cycles: one pulse, busy six cycles
    step(1,0,0, MULT, 16'h2000, 0, AUX3, 0,0,0, 1,0,1);
    for (int i = 0; i < 3; i++)
      step(1,1,0, NOP, 16'h2100, 0, 48'h0, 0,0,0, 0,0,1);
    step(1,0,0, NOP, 16'h2004, 0, 48'h0, 0,0,0, 0,0,1);
    step(1,0,0, NOP, 16'h2008, 0, 48'h0, 0,0,0, 0,0,1);
    step(1,0,0, NOP, 16'h200C, 0, 48'h0, 0,0,0, 0,0,0);
    // div then a mult held behind it; mult issues when the count expires
    step(1,0,0, DIV,  16'h2200, 1, 48'h8, 0,0,0, 1,2,1);
    step(1,0,0, MULT, 16'h2204, 0, 48'h9, 0,0,0, 0,0,1);
    for (int i = 0; i < 9; i++)
      step(1,1,0, NOP, 16'h2300, 0, 48'h0, 0,0,0, 0,0,1);
    step(1,1,0, NOP, 16'h2300, 0, 48'h0, 0,0,0, 1,0,1);
    for (int i = 0; i < 5; i++)
      step(1,0,1, NOP, 16'h2400, 0, 48'h0, 0,0,0, 0,0,1);
    step(1,0,1, NOP, 16'h2400, 0, 48'h0, 0,0,0, 0,0,0);
    // flush right after a div issue: busy still spans 11 cycles
    step(1,0,0, DIV, 16'h2500, 0, 48'hA, 0,0,0, 1,2,1);
    for (int i = 0; i < 10; i++)
      step(1,0,1, DIV, 16'h2504, 0, 48'hB, 0,0,0, 0,0,1);
    step(1,0,1, DIV, 16'h2508, 0, 48'hB, 0,0,0, 0,0,0);
    // asynchronous reset in the middle of a count
    step(1,0,0, MULT, 16'h2600, 1, AUX3, 0,0,0, 1,0,1);
    step(1,0,0, NOP,  16'h2604, 1, 48'hC, 0,0,0, 0,0,1);
    step(0,0,0, NOP,  16'h2608, 1, 48'hD, 0,0,0, 0,0,0);
    #1;
    chk(-1, "async_valid_e", 64'(valid_e), 64'd0);
    chk(-1, "async_md_busy", 64'(md_busy), 64'd0);
    chk(-1, "async_pc_e", 64'(pc_e), 64'd0);
    step(1,0,0, NOP, 16'h2700, 0, AUX3, 0,0,0, 0,0,0);
    step(1,0,0, ADDU, 16'h2704, 1, 48'hE, 0,0,1, 0,0,0);

    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
